hcsr04_distance_meter: RTL

//  Drives an HC-SR04 ultrasonic sensor: issues a trigger pulse, times the echo and converts its width to cm.

---
 rtl/sensor_pkg.sv | 15 +
 rtl/tick_us_gen.sv | 28 ++
 rtl/hcsr04_distance_meter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and FSM state type for the ultrasonic ranging blocks.
package sensor_pkg;
  localparam int unsigned CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned DATA_W      = 14;
  localparam int unsigned US_PER_CM   = 58;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE,
    ERR
  } state_t;
endpackage

// File: rtl/tick_us_gen.sv
// Clearable 1 us tick generator: one-cycle tick every CLK_PER_US clocks.
module tick_us_gen #(
  parameter int unsigned CLK_PER_US = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CNT_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [CNT_W-1:0] cnt;

  // The clear cycle counts as the first cycle of the new period, so the
  // first tick lands exactly CLK_PER_US cycles after a state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= (CLK_PER_US > 1) ? CNT_W'(1) : '0;
    else if (cnt == CNT_W'(CLK_PER_US - 1))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == CNT_W'(CLK_PER_US - 1));
endmodule

// File: rtl/hcsr04_distance_meter.sv
// HC-SR04 driver: trigger pulse, echo timing, width-to-cm conversion by
// counting whole centimetres of echo time (no divider).
module hcsr04_distance_meter
  import sensor_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = sensor_pkg::CLK_FREQ_HZ,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned US_PER_CM   = sensor_pkg::US_PER_CM,
  parameter int unsigned TIMEOUT_US  = 30000,
  parameter int unsigned DATA_W      = sensor_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DATA_W-1:0] distance,
  output logic              valid,
  output logic              busy,
  output logic              error
);
  localparam int unsigned CLK_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned TRIG_CYC   = TRIG_US * CLK_PER_US;
  localparam int unsigned TRIG_W     = $clog2(TRIG_CYC + 1);
  localparam int unsigned TO_W       = $clog2(TIMEOUT_US + 1);
  localparam int unsigned SUB_W      = $clog2(US_PER_CM + 1);

  state_t            state;
  logic              echo_s1, echo_s2, echo_d;
  logic              echo_rise, echo_fall;
  logic              tick_clr, tick;
  logic [TRIG_W-1:0] trig_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [DATA_W-1:0] cm_cnt, cm_next;
  logic              cm_step, to_expire;

  tick_us_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign echo_rise = echo_s2 && !echo_d;
  assign echo_fall = !echo_s2 && echo_d;

  // cm_next folds in a tick coinciding with the falling edge, so DONE
  // latches a count that includes the final microsecond.
  always_comb begin
    cm_step   = tick && (sub_cnt == SUB_W'(US_PER_CM - 1));
    to_expire = tick && (to_cnt == TO_W'(TIMEOUT_US - 1));
    cm_next   = cm_cnt;
    if (cm_step && (cm_cnt != '1))
      cm_next = cm_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      trig     <= 1'b0;
      distance <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      tick_clr <= 1'b0;
      trig_cnt <= '0;
      to_cnt   <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
    end else begin
      tick_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= TRIG;
            trig     <= 1'b1;
            busy     <= 1'b1;
            error    <= 1'b0;
            trig_cnt <= '0;
            tick_clr <= 1'b1;
          end
        end
        TRIG: begin
          if (trig_cnt == TRIG_W'(TRIG_CYC - 1)) begin
            trig     <= 1'b0;
            state    <= WAIT_ECHO;
            to_cnt   <= '0;
            tick_clr <= 1'b1;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end
        WAIT_ECHO: begin
          if (echo_rise) begin
            state    <= MEASURE;
            to_cnt   <= '0;
            sub_cnt  <= '0;
            cm_cnt   <= '0;
            tick_clr <= 1'b1;
          end else if (to_expire) begin
            state    <= ERR;
            error    <= 1'b1;
            tick_clr <= 1'b1;
          end else if (tick) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            state    <= DONE;
            distance <= cm_next;
            valid    <= 1'b1;
            tick_clr <= 1'b1;
          end else if (to_expire) begin
            state    <= ERR;
            error    <= 1'b1;
            tick_clr <= 1'b1;
          end else if (tick) begin
            to_cnt  <= to_cnt + 1'b1;
            sub_cnt <= cm_step ? '0 : sub_cnt + 1'b1;
            cm_cnt  <= cm_next;
          end
        end
        DONE: begin
          valid    <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
          tick_clr <= 1'b1;
        end
        ERR: begin
          busy     <= 1'b0;
          state    <= IDLE;
          tick_clr <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
